// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared constants, types and helpers for the MIPS
//               instruction-decode stage: opcode/funct codes, instruction
//               class enum, field bit positions and the legality check used
//               when ID_ILLEGAL_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Field bit positions within the 32-bit instruction word
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ITYPE_R = 2'd0,
        ITYPE_I = 2'd1,
        ITYPE_J = 2'd2
    } itype_t;

    // True when the word is outside the supported MIPS subset.
    function automatic logic is_illegal(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[OPCODE_MSB:OPCODE_LSB];
        fn = instr[FUNCT_MSB:FUNCT_LSB];
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU, FN_SUB,
                    FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT,
                    FN_SLTU:  is_illegal = 1'b0;
                    default:  is_illegal = 1'b1;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW,
            OP_SW:    is_illegal = 1'b0;
            default:  is_illegal = 1'b1;
        endcase
    endfunction

endpackage : id_pkg
`default_nettype wire

// File: rtl/id_field_extract.sv
`default_nettype none
// ============================================================================
// Module      : id_field_extract
// Description : Purely combinational field slicer for a 32-bit MIPS word.
//               Produces register/shift/function fields, the extended
//               immediate (zero-extend for andi/ori/xori, upper-placed for
//               lui, sign-extend otherwise), jump target and instruction
//               class.
// Ports       : instr   - 32-bit instruction word
//               opcode/rs/rt/rd/shamt/funct/jaddr - raw field slices
//               imm_ext - IMM_W-bit extended immediate
//               itype   - R / I / J class
// Revision    : 1.0 - initial release
// ============================================================================
module id_field_extract
    import id_pkg::*;
#(
    parameter int IMM_W = 32
) (
    input  logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [IMM_W-1:0] imm_ext,
    output logic [25:0]      jaddr,
    output itype_t           itype
);

    logic [15:0]      w_imm16;
    logic [IMM_W-1:0] w_zext;
    logic [IMM_W-1:0] w_sext;
    logic [IMM_W-1:0] w_lui;

    assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign rt      = instr[RT_MSB:RT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign shamt   = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
    assign jaddr   = instr[JADDR_MSB:JADDR_LSB];
    assign w_imm16 = instr[IMM_MSB:IMM_LSB];

    // Size casts keep this valid down to IMM_W == 16, where a zero-width
    // replication would otherwise be needed.
    assign w_zext = IMM_W'(w_imm16);
    assign w_sext = IMM_W'($signed(w_imm16));
    assign w_lui  = w_zext << (IMM_W - 16);

    always_comb begin
        imm_ext = w_sext;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = w_zext;
            OP_LUI:                   imm_ext = w_lui;
            default:                  imm_ext = w_sext;
        endcase
    end

    always_comb begin
        itype = ITYPE_I;
        case (opcode)
            OP_RTYPE:    itype = ITYPE_R;
            OP_J, OP_JAL: itype = ITYPE_J;
            default:     itype = ITYPE_I;
        endcase
    end

endmodule : id_field_extract
`default_nettype wire

// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_stage
// Description : Registered MIPS instruction-decode stage. Instruction + PC
//               arrive over valid/ready and are held in a main register
//               backed by a one-entry skid register, so in_ready is a pure
//               register output (no combinational path from out_ready).
//               Decoded fields are sliced combinationally from the main
//               register. flush drops everything held.
// Ports       : clk, rst_n (async, active low), flush
//               in_valid/in_ready/in_instr/in_pc   - upstream handshake
//               out_valid/out_ready/out_pc          - downstream handshake
//               opcode, rs, rt, rd, shamt, funct, imm_ext, jaddr, itype
//               illegal (only with ID_ILLEGAL_DETECT_EN)
// Options     : define ID_ILLEGAL_DETECT_EN to add the illegal output.
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode_stage
    import id_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IMM_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [IMM_W-1:0] imm_ext,
    output logic [25:0]      jaddr,
`ifdef ID_ILLEGAL_DETECT_EN
    output logic             illegal,
`endif
    output logic [1:0]       itype
);

    logic [31:0]     r_main_instr;
    logic [PC_W-1:0] r_main_pc;
    logic            r_out_valid;
    logic [31:0]     r_skid_instr;
    logic [PC_W-1:0] r_skid_pc;
    logic            r_skid_valid;
`ifdef ID_ILLEGAL_DETECT_EN
    logic            r_main_illegal;
    logic            r_skid_illegal;
`endif

    logic   w_in_xfer;
    logic   w_out_xfer;
    itype_t w_itype;

    assign in_ready   = ~r_skid_valid;
    assign out_valid  = r_out_valid;
    assign out_pc     = r_main_pc;
    assign w_in_xfer  = in_valid & ~r_skid_valid;
    assign w_out_xfer = r_out_valid & out_ready;

    // Skid occupied implies main occupied, so the branches below cover:
    // refill main from skid, load/drain main directly, or park the input
    // in skid while downstream is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_instr   <= '0;
            r_main_pc      <= '0;
            r_out_valid    <= 1'b0;
            r_skid_instr   <= '0;
            r_skid_pc      <= '0;
            r_skid_valid   <= 1'b0;
`ifdef ID_ILLEGAL_DETECT_EN
            r_main_illegal <= 1'b0;
            r_skid_illegal <= 1'b0;
`endif
        end else if (flush) begin
            // Data registers intentionally keep stale contents.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_xfer && r_skid_valid) begin
            r_main_instr   <= r_skid_instr;
            r_main_pc      <= r_skid_pc;
            r_out_valid    <= 1'b1;
            r_skid_valid   <= 1'b0;
`ifdef ID_ILLEGAL_DETECT_EN
            r_main_illegal <= r_skid_illegal;
`endif
        end else if ((!r_out_valid || out_ready) && !r_skid_valid) begin
            r_out_valid <= w_in_xfer;
            if (w_in_xfer) begin
                r_main_instr   <= in_instr;
                r_main_pc      <= in_pc;
`ifdef ID_ILLEGAL_DETECT_EN
                r_main_illegal <= is_illegal(in_instr);
`endif
            end
        end else if (w_in_xfer) begin
            r_skid_instr   <= in_instr;
            r_skid_pc      <= in_pc;
            r_skid_valid   <= 1'b1;
`ifdef ID_ILLEGAL_DETECT_EN
            r_skid_illegal <= is_illegal(in_instr);
`endif
        end
    end

`ifdef ID_ILLEGAL_DETECT_EN
    assign illegal = r_main_illegal;
`endif

    id_field_extract #(
        .IMM_W   (IMM_W)
    ) u_field_extract (
        .instr   (r_main_instr),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm_ext (imm_ext),
        .jaddr   (jaddr),
        .itype   (w_itype)
    );

    assign itype = w_itype;

endmodule : id_decode_stage
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_decode_stage
// Description : Self-checking bench for id_decode_stage. A two-deep
//               in-order queue stands in for the stage: an item is taken
//               whenever fewer than two are held, the head leaves on
//               out_ready, and flush empties it. Decoded fields of the head
//               are derived from the MIPS field rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [25:0] jaddr;
    logic [1:0]  itype;
`ifdef ID_ILLEGAL_DETECT_EN
    logic        illegal;
`endif

    id_decode_stage #(
        .PC_W      (32),
        .IMM_W     (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm_ext   (imm_ext),
        .jaddr     (jaddr),
`ifdef ID_ILLEGAL_DETECT_EN
        .illegal   (illegal),
`endif
        .itype     (itype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] popped[$];
    int          checks   = 0;
    int          failures = 0;

    // ---------------- reference decode ----------------
    function automatic logic [31:0] exp_imm(input logic [31:0] w);
        int unsigned op  = w >> 26;
        int unsigned imm = w & 32'hFFFF;
        if (op == 12 || op == 13 || op == 14) return imm;
        if (op == 15)                         return imm * 65536;
        if (imm >= 32768)                     return imm + 32'hFFFF0000;
        return imm;
    endfunction

    function automatic logic [1:0] exp_itype(input logic [31:0] w);
        int unsigned op = w >> 26;
        if (op == 0)            return 2'd0;
        if (op == 2 || op == 3) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic exp_illegal(input logic [31:0] w);
        int unsigned op = w >> 26;
        int unsigned fn = w & 63;
        if (op == 0)
            return !(fn inside {0, 2, 3, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43});
        return !(op inside {0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_fields();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_pc",    64'(out_pc),    64'd0);
        chk("rst_opcode",    64'(opcode),    64'd0);
        chk("rst_rs",        64'(rs),        64'd0);
        chk("rst_rt",        64'(rt),        64'd0);
        chk("rst_rd",        64'(rd),        64'd0);
        chk("rst_shamt",     64'(shamt),     64'd0);
        chk("rst_funct",     64'(funct),     64'd0);
        chk("rst_imm_ext",   64'(imm_ext),   64'd0);
        chk("rst_jaddr",     64'(jaddr),     64'd0);
        chk("rst_itype",     64'(itype),     64'd0);
`ifdef ID_ILLEGAL_DETECT_EN
        chk("rst_illegal",   64'(illegal),   64'd0);
`endif
    endtask

    task automatic check_all();
        logic [31:0] w;
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            w = q[0].instr;
            chk("out_pc",  64'(out_pc),  64'(q[0].pc));
            chk("opcode",  64'(opcode),  64'((w >> 26) & 63));
            chk("rs",      64'(rs),      64'((w >> 21) & 31));
            chk("rt",      64'(rt),      64'((w >> 16) & 31));
            chk("rd",      64'(rd),      64'((w >> 11) & 31));
            chk("shamt",   64'(shamt),   64'((w >> 6) & 31));
            chk("funct",   64'(funct),   64'(w & 63));
            chk("imm_ext", 64'(imm_ext), 64'(exp_imm(w)));
            chk("jaddr",   64'(jaddr),   64'(w & 32'h03FFFFFF));
            chk("itype",   64'(itype),   64'(exp_itype(w)));
`ifdef ID_ILLEGAL_DETECT_EN
            chk("illegal", 64'(illegal), 64'(exp_illegal(w)));
`endif
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, check.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, output logic accepted);
        int  cnt;
        logic pop;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        cnt       = q.size();
        pop       = (cnt > 0) && ordy;
        accepted  = iv && (cnt < 2) && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) popped.push_back(q.pop_front().pc);
            if (accepted) q.push_back('{instr: ins, pc: pc});
        end
        #1;
        check_all();
    endtask

    logic [5:0] op_tab [16];
    logic [31:0] r;
    logic [31:0] pc_n;
    logic        acc;
    int          sent;

    initial begin
        op_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                   6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_fields();
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        check_zero_fields();

        // addi then ori
        cycle(1'b1, 32'h2128FFFC, 32'h100, 1'b1, 1'b0, acc);
        chk("addi_opcode", 64'(opcode), 64'h08);
        chk("addi_rs",     64'(rs),     64'd9);
        chk("addi_rt",     64'(rt),     64'd8);
        chk("addi_imm",    64'(imm_ext), 64'hFFFFFFFC);
        chk("addi_itype",  64'(itype),  64'd1);
        cycle(1'b1, 32'h3528FFFC, 32'h104, 1'b1, 1'b0, acc);
        chk("ori_imm",     64'(imm_ext), 64'h0000FFFC);
        cycle(1'b1, 32'h3C0A1234, 32'h108, 1'b1, 1'b0, acc);
        chk("lui_imm",     64'(imm_ext), 64'h12340000);
        cycle(1'b1, 32'h0C000010, 32'h10C, 1'b1, 1'b0, acc);
        chk("jal_itype",   64'(itype),  64'd2);
        chk("jal_jaddr",   64'(jaddr),  64'h10);
        cycle(1'b1, 32'h012A4020, 32'h110, 1'b1, 1'b0, acc);
        chk("add_itype",   64'(itype),  64'd0);
        chk("add_rd",      64'(rd),     64'd8);
        chk("add_funct",   64'(funct),  64'h20);
`ifdef ID_ILLEGAL_DETECT_EN
        cycle(1'b1, 32'hFC000000, 32'h114, 1'b1, 1'b0, acc);
        chk("ill_3f",      64'(illegal), 64'd1);
        cycle(1'b1, 32'h8D090004, 32'h118, 1'b1, 1'b0, acc);
        chk("ill_lw",      64'(illegal), 64'd0);
`endif
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Stream of 8 with a two-cycle downstream stall
        popped.delete();
        sent = 0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            r = $urandom;
            cycle(sent < 8, r, 32'h1000 + 32'(sent) * 4,
                  !(c == 1 || c == 2), 1'b0, acc);
            if (acc) sent++;
        end
        chk("stream_count", 64'(popped.size()), 64'd8);
        for (int i = 0; i < popped.size() && i < 8; i++)
            chk("stream_pc", 64'(popped[i]), 64'h1000 + 64'(i) * 4);

        // Flush with main and skid full and a new input pending
        cycle(1'b1, 32'h2108_0001, 32'hDEAD0000, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h2108_0002, 32'hDEAD0004, 1'b0, 1'b0, acc);
        chk("pre_flush_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h2108_0003, 32'hDEAD0008, 1'b0, 1'b1, acc);
        chk("flush_valid",  64'(out_valid), 64'd0);
        chk("flush_ready",  64'(in_ready),  64'd1);
        cycle(1'b1, 32'h2108_0004, 32'h2000, 1'b1, 1'b0, acc);
        chk("post_flush_pc", 64'(out_pc), 64'h2000);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Randomised traffic with occasional flushes
        pc_n = 32'h4000;
        for (int c = 0; c < 400; c++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 1) r[31:26] = op_tab[$urandom_range(0, 15)];
            cycle($urandom_range(0, 3) != 0, r, pc_n, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, acc);
            if (acc) pc_n += 4;
        end

        // Reset mid-stream
        cycle(1'b1, 32'h2128FFFC, 32'h8000, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h3528FFFC, 32'h8004, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_fields();
        q.delete();
        @(posedge clk);
        #1;
        check_zero_fields();
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        check_zero_fields();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_decode_stage
`default_nettype wire
